spi_secondary_tx: RTL and testbench

- SPI secondary transmit path, mode 0 (CPOL=0, CPHA=0), MSB first; drives the top-level miso pin back to the SPI main.
- Complements the existing SPI secondary receiver; both sit side by side on the same sck/cs pins.
- Bytes come from a one-entry holding register loaded through a valid/ready handshake, typically fed by a Fifo read port.
- sck and cs are oversampled in the clk domain; no logic is clocked by sck.

---
 rtl/spi_secondary_tx_pkg.sv | 14 +
 rtl/spi_secondary_tx_pin_sync.sv | 32 +++
 rtl/spi_secondary_tx.sv | 168 ++++++++++++++++
 tb/tb_spi_secondary_tx.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_secondary_tx_pkg.sv
// Shared constants and state encoding for the SPI secondary transmit/receive pair.
// The receiver reuses SPI_WORD_WIDTH so both directions agree on the word size.
package spi_secondary_tx_pkg;

  localparam int SPI_WORD_WIDTH = 8;
  localparam logic [SPI_WORD_WIDTH-1:0] SPI_IDLE_WORD = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_RELOAD = 2'd2
  } tx_state_e;

endpackage

// File: rtl/spi_secondary_tx_pin_sync.sv
// spi_pin_sync: N-stage synchroniser for an asynchronous pin, with single-cycle
// rise/fall pulses derived from the synchronised level and one history flop.
module spi_pin_sync #(
  parameter int   STAGES      = 2,
  parameter logic RESET_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_pin,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_hist;
  logic              w_level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {STAGES{RESET_LEVEL}};
      r_hist <= RESET_LEVEL;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_pin};
      r_hist <= r_sync[STAGES-1];
    end
  end

  assign w_level = r_sync[STAGES-1];
  assign o_rise  = w_level & ~r_hist;
  assign o_fall  = ~w_level & r_hist;

endmodule

// File: rtl/spi_secondary_tx.sv
// SPI mode-0 secondary transmitter, MSB first, oversampling sck/cs in the clk domain.
// Define SPI_TX_UNDERRUN_COUNT_EN to add the saturating underrun_count/underrun_clear pair.
module spi_secondary_tx
  import spi_secondary_tx_pkg::*;
#(
  parameter int                    DATA_WIDTH  = SPI_WORD_WIDTH,
  parameter logic [DATA_WIDTH-1:0] IDLE_WORD   = SPI_IDLE_WORD,
  parameter int                    SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sck,
  input  logic                  cs,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  miso,
  output logic                  miso_oe,
  output logic                  word_sent,
  output logic                  underrun
`ifdef SPI_TX_UNDERRUN_COUNT_EN
  ,
  input  logic                  underrun_clear,
  output logic [7:0]            underrun_count
`endif
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  tx_state_e             r_state, w_state_next;
  logic [DATA_WIDTH-1:0] r_shift, w_shift_next;
  logic [CNT_W-1:0]      r_bit_cnt, w_bit_cnt_next;
  logic                  r_miso, w_miso_next;
  logic                  r_miso_oe, w_miso_oe_next;
  logic                  r_word_sent, w_word_sent_next;
  logic                  r_underrun, w_underrun_next;
  logic [DATA_WIDTH-1:0] r_hold;
  logic                  r_hold_full;
  logic                  w_load;
  logic                  w_write;
  logic [DATA_WIDTH-1:0] w_load_word;
  logic                  w_sck_rise, w_sck_fall, w_cs_rise, w_cs_fall;

  spi_pin_sync #(.STAGES(SYNC_STAGES), .RESET_LEVEL(1'b0)) u_sck_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_pin  (sck),
    .o_rise (w_sck_rise),
    .o_fall (w_sck_fall)
  );

  spi_pin_sync #(.STAGES(SYNC_STAGES), .RESET_LEVEL(1'b1)) u_cs_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_pin  (cs),
    .o_rise (w_cs_rise),
    .o_fall (w_cs_fall)
  );

  assign w_write     = tx_valid & ~r_hold_full;
  assign w_load_word = r_hold_full ? r_hold : IDLE_WORD;

  // cs_rise overrides everything; a load in IDLE or RELOAD shares one path.
  always_comb begin
    w_state_next     = r_state;
    w_shift_next     = r_shift;
    w_bit_cnt_next   = r_bit_cnt;
    w_miso_next      = r_miso;
    w_miso_oe_next   = r_miso_oe;
    w_word_sent_next = 1'b0;
    w_underrun_next  = 1'b0;
    w_load           = 1'b0;
    if (w_cs_rise) begin
      w_state_next   = ST_IDLE;
      w_bit_cnt_next = '0;
      w_miso_oe_next = 1'b0;
      w_miso_next    = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_miso_next    = 1'b1;
          w_miso_oe_next = 1'b0;
          if (w_cs_fall) w_load = 1'b1;
        end
        ST_SHIFT: begin
          if (w_sck_rise) begin
            w_bit_cnt_next = r_bit_cnt + 1'b1;
            if (r_bit_cnt == LAST_BIT) begin
              w_word_sent_next = 1'b1;
              w_state_next     = ST_RELOAD;
            end
          end else if (w_sck_fall) begin
            w_shift_next = r_shift << 1;
            w_miso_next  = r_shift[DATA_WIDTH-2];
          end
        end
        ST_RELOAD: begin
          if (w_sck_fall) w_load = 1'b1;
        end
        default: w_state_next = ST_IDLE;
      endcase
      if (w_load) begin
        w_shift_next    = w_load_word;
        w_miso_next     = w_load_word[DATA_WIDTH-1];
        w_bit_cnt_next  = '0;
        w_miso_oe_next  = 1'b1;
        w_underrun_next = ~r_hold_full;
        w_state_next    = ST_SHIFT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_miso      <= 1'b1;
      r_miso_oe   <= 1'b0;
      r_word_sent <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      r_shift     <= w_shift_next;
      r_bit_cnt   <= w_bit_cnt_next;
      r_miso      <= w_miso_next;
      r_miso_oe   <= w_miso_oe_next;
      r_word_sent <= w_word_sent_next;
      r_underrun  <= w_underrun_next;
    end
  end

  // A load only sees the occupancy from the start of the cycle, so a same-cycle write stays held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
    end else if (w_write) begin
      r_hold      <= tx_data;
      r_hold_full <= 1'b1;
    end else if (w_load) begin
      r_hold_full <= 1'b0;
    end
  end

  assign tx_ready  = ~r_hold_full;
  assign miso      = r_miso;
  assign miso_oe   = r_miso_oe;
  assign word_sent = r_word_sent;
  assign underrun  = r_underrun;

`ifdef SPI_TX_UNDERRUN_COUNT_EN
  logic [7:0] r_underrun_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                         r_underrun_count <= 8'h00;
    else if (underrun_clear)                            r_underrun_count <= 8'h00;
    else if (r_underrun && (r_underrun_count != 8'hFF)) r_underrun_count <= r_underrun_count + 8'h01;
  end

  assign underrun_count = r_underrun_count;
`endif

endmodule

// File: tb/tb_spi_secondary_tx.sv
// Self-checking bench for spi_secondary_tx: a word-level model of what the main
// should receive, plus a per-cycle compare of miso/miso_oe once the pins have settled.
module tb_spi_secondary_tx;

  localparam int HALF   = 6;
  localparam int SETTLE = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sck;
  logic       cs;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       miso;
  logic       miso_oe;
  logic       word_sent;
  logic       underrun;
`ifdef SPI_TX_UNDERRUN_COUNT_EN
  logic       underrun_clear;
  logic [7:0] underrun_count;
`endif

  int checks = 0;
  int errors = 0;

  // Model of the transmitter at word level: what is held, what is on the wire, which bit.
  logic       mFull;
  logic [7:0] mHold;
  logic [7:0] mWord;
  int         mBit;
  int         expSent;
  int         expUnder;
  int         modelCnt;
  int         seenSent;
  int         seenUnder;
  logic [15:0] rxWord;

  int   csSettle;
  int   sckSettle;
  logic lastCs;
  logic lastSck;

  spi_secondary_tx dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .sck            (sck),
    .cs             (cs),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .miso           (miso),
    .miso_oe        (miso_oe),
    .word_sent      (word_sent),
    .underrun       (underrun)
`ifdef SPI_TX_UNDERRUN_COUNT_EN
    ,
    .underrun_clear (underrun_clear),
    .underrun_count (underrun_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every pin change happens just after a falling clk edge so samplers at the edge see stable values.
  task automatic stepTo();
    @(negedge clk);
    #1;
  endtask

  // A load takes the held word if any, otherwise the idle word with an underrun.
  task automatic modelLoad();
    if (mFull) begin
      mWord = mHold;
      mFull = 1'b0;
    end else begin
      mWord = 8'hFF;
      expUnder++;
      if (modelCnt < 255) modelCnt++;
    end
    mBit = 0;
  endtask

  task automatic writeWord(input logic [7:0] d);
    int n;
    stepTo();
    tx_data  = d;
    tx_valid = 1'b1;
    n = 0;
    while (!tx_ready && n < 20) begin
      stepTo();
      n++;
    end
    checkOutput("tx_ready_wait", tx_ready, 1);
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    mFull    = 1'b1;
    mHold    = d;
  endtask

  task automatic selectCs();
    stepTo();
    cs = 1'b0;
    modelLoad();
    rxWord = '0;
    repeat (6) stepTo();
  endtask

  task automatic deselectCs();
    stepTo();
    cs   = 1'b1;
    mBit = 0;
    repeat (6) stepTo();
  endtask

  // Clock n sck cycles; the main samples miso just before each rising edge.
  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      stepTo();
      checkOutput("miso_bit", miso, mWord[7-mBit]);
      rxWord = {rxWord[14:0], miso};
      sck    = 1'b1;
      mBit++;
      if (mBit == 8) expSent++;
      repeat (HALF) stepTo();
      sck = 1'b0;
      if (mBit == 8) modelLoad();
      repeat (HALF - 1) stepTo();
    end
  endtask

  task automatic checkCounts();
    repeat (4) stepTo();
    checkOutput("word_sent_pulses", seenSent, expSent);
    checkOutput("underrun_pulses", seenUnder, expUnder);
  endtask

  // Track how long cs and sck have been stable so the per-cycle compare only judges settled outputs.
  always @(posedge clk) begin
    if (!rst_n || cs !== lastCs) csSettle = 0;
    else                         csSettle++;
    if (!rst_n || sck !== lastSck) sckSettle = 0;
    else                           sckSettle++;
    lastCs  = cs;
    lastSck = sck;
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (word_sent) seenSent++;
      if (underrun)  seenUnder++;
      if (csSettle >= SETTLE) begin
        checkOutput("miso_oe", miso_oe, !lastCs);
        if (lastCs) checkOutput("miso_idle", miso, 1);
        else if (!lastSck && sckSettle >= SETTLE) checkOutput("miso_cycle", miso, mWord[7-mBit]);
      end
    end
  end

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n    = 1'b0;
    sck      = 1'b0;
    cs       = 1'b1;
    tx_data  = 8'h00;
    tx_valid = 1'b0;
`ifdef SPI_TX_UNDERRUN_COUNT_EN
    underrun_clear = 1'b0;
`endif
    mFull = 1'b0; mHold = '0; mWord = 8'hFF; mBit = 0;
    expSent = 0; expUnder = 0; modelCnt = 0;
    seenSent = 0; seenUnder = 0; rxWord = '0;
    csSettle = 0; sckSettle = 0; lastCs = 1'b1; lastSck = 1'b0;

    repeat (3) stepTo();
    checkOutput("reset_tx_ready", tx_ready, 1);
    checkOutput("reset_miso", miso, 1);
    checkOutput("reset_miso_oe", miso_oe, 0);
    checkOutput("reset_word_sent", word_sent, 0);
    checkOutput("reset_underrun", underrun, 0);
    rst_n = 1'b1;
    repeat (4) stepTo();

    $display("[TB] single word A5");
    writeWord(8'hA5);
    checkOutput("held_not_ready", tx_ready, 0);
    selectCs();
    checkOutput("ready_after_load", tx_ready, 1);
    applyStimulus(8);
    checkOutput("rx_A5", rxWord[7:0], 8'hA5);
    checkCounts();
    checkOutput("sent_literal_1", seenSent, 1);
    deselectCs();

    $display("[TB] back-to-back 3C then C3");
    writeWord(8'h3C);
    selectCs();
    applyStimulus(2);
    writeWord(8'hC3);
    applyStimulus(14);
    checkOutput("rx_3CC3", rxWord, 16'h3CC3);
    checkCounts();
    checkOutput("sent_literal_3", seenSent, 3);
    deselectCs();

    $display("[TB] underrun on select");
    selectCs();
    repeat (4) stepTo();
    checkOutput("underrun_at_select", seenUnder, expUnder);
    applyStimulus(8);
    checkOutput("rx_FF", rxWord[7:0], 8'hFF);
    checkCounts();
    deselectCs();

    $display("[TB] abort after 3 bits of 81, then 7E");
    writeWord(8'h81);
    selectCs();
    applyStimulus(3);
    checkOutput("rx_81_partial", rxWord[2:0], 3'b100);
    deselectCs();
    writeWord(8'h7E);
    selectCs();
    applyStimulus(8);
    checkOutput("rx_7E", rxWord[7:0], 8'h7E);
    checkCounts();
    deselectCs();

    $display("[TB] reset mid-word with 55 held");
    writeWord(8'hAA);
    selectCs();
    writeWord(8'h55);
    applyStimulus(3);
    stepTo();
    rst_n = 1'b0;
    mFull = 1'b0; mBit = 0; modelCnt = 0;
    #1;
    checkOutput("rst_tx_ready", tx_ready, 1);
    checkOutput("rst_miso", miso, 1);
    checkOutput("rst_miso_oe", miso_oe, 0);
    checkOutput("rst_word_sent", word_sent, 0);
    checkOutput("rst_underrun", underrun, 0);
    cs = 1'b1;
    repeat (3) stepTo();
    rst_n = 1'b1;
    repeat (6) stepTo();
    checkOutput("post_rst_tx_ready", tx_ready, 1);
    selectCs();
    applyStimulus(8);
    checkOutput("rx_after_reset", rxWord[7:0], 8'hFF);
    checkCounts();
    deselectCs();

`ifdef SPI_TX_UNDERRUN_COUNT_EN
    $display("[TB] underrun counter saturation");
    checkOutput("cnt_small", underrun_count, modelCnt);
    selectCs();
    applyStimulus(300 * 8);
    deselectCs();
    checkOutput("cnt_model", underrun_count, modelCnt);
    checkOutput("cnt_saturated", underrun_count, 8'hFF);
    stepTo();
    underrun_clear = 1'b1;
    stepTo();
    underrun_clear = 1'b0;
    modelCnt = 0;
    stepTo();
    checkOutput("cnt_cleared", underrun_count, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
